// File: rtl/spi_target_pkg.sv
// Shared constants for the SPI target: frame size, FSM encodings and the
// synchroniser settle count used after reset.
package spi_target_pkg;

    localparam int SPI_FRAME_SIZE = 40;

    localparam logic [1:0] ST_WAIT_HIGH = 2'd0;
    localparam logic [1:0] ST_IDLE      = 2'd1;
    localparam logic [1:0] ST_SHIFT     = 2'd2;

    // Cycles needed before the synchronised CS_n reflects the pin rather than the reset value
    localparam logic [1:0] SETTLE_CYCLES = 2'd2;

endpackage

// File: rtl/spi_target_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, followed by an edge detector
// built on a registered copy of the synchronised level.
module spi_target_sync_edge #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_in,
    input  logic reset_n_in,
    input  logic async_in,
    output logic sync_out,
    output logic rise_out,
    output logic fall_out
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
            prev_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise_out = sync_q & ~prev_q;
    assign fall_out = ~sync_q & prev_q;

endmodule

// File: rtl/spi_target.sv
// Mode-0 SPI target: shifts a SIZE-bit MOSI frame into data_out and returns
// data_in on MISO, with SCK/CS_n/MOSI oversampled in the clk_in domain.
module spi_target
    import spi_target_pkg::*;
#(
    parameter int SIZE      = SPI_FRAME_SIZE,
    parameter int CNT_WIDTH = 6
) (
    input  logic            clk_in,
    input  logic            reset_n_in,
    input  logic            sck_in,
    input  logic            cs_n_in,
    input  logic            mosi_in,
    output logic            miso_out,
    output logic            miso_oe_out,
    input  logic [SIZE-1:0] data_in,
    output logic [SIZE-1:0] data_out,
    output logic            r_valid_out,
    output logic            r_frame_err_out,
    output logic            r_busy_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(SIZE);
    localparam logic [CNT_WIDTH-1:0] CNT_SAT  = CNT_WIDTH'(SIZE + 1);

    logic sck_level_unused, sck_rise, sck_fall;
    logic cs_sync, cs_rise, cs_fall;
    logic mosi_meta_q, mosi_sync_q;

    logic [1:0]           state_q, state_d;
    logic [1:0]           settle_q, settle_d;
    logic [CNT_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [SIZE-1:0]      tx_shift_q, tx_shift_d;
    logic [SIZE-1:0]      rx_shift_q, rx_shift_d;
    logic [SIZE-1:0]      data_out_q, data_out_d;
    logic                 miso_q, miso_d;
    logic                 oe_q, oe_d;
    logic                 valid_q, valid_d;
    logic                 err_q, err_d;
    logic                 busy_q, busy_d;

    spi_target_sync_edge #(.RESET_VAL(1'b1)) u_sck_sync (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .async_in   (sck_in),
        .sync_out   (sck_level_unused),
        .rise_out   (sck_rise),
        .fall_out   (sck_fall)
    );

    spi_target_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .async_in   (cs_n_in),
        .sync_out   (cs_sync),
        .rise_out   (cs_rise),
        .fall_out   (cs_fall)
    );

    // MOSI shares the two-stage delay of SCK so the sampled bit lines up with sck_rise
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            mosi_meta_q <= 1'b1;
            mosi_sync_q <= 1'b1;
        end else begin
            mosi_meta_q <= mosi_in;
            mosi_sync_q <= mosi_meta_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        bit_cnt_d  = bit_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        data_out_d = data_out_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        busy_d     = busy_q;
        valid_d    = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            ST_WAIT_HIGH: begin
                // Wait out the reset value in the synchroniser so a CS held low never starts a frame
                if (settle_q != SETTLE_CYCLES) begin
                    settle_d = settle_q + 2'd1;
                end else if (cs_sync) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cs_fall) begin
                    tx_shift_d = data_in;
                    bit_cnt_d  = '0;
                    miso_d     = data_in[SIZE-1];
                    oe_d       = 1'b1;
                    busy_d     = 1'b1;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (cs_rise) begin
                    if (bit_cnt_q == CNT_FULL) begin
                        data_out_d = rx_shift_q;
                        valid_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    oe_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (sck_rise) begin
                    rx_shift_d = {rx_shift_q[SIZE-2:0], mosi_sync_q};
                    if (bit_cnt_q != CNT_SAT) begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end else if (sck_fall) begin
                    tx_shift_d = {tx_shift_q[SIZE-2:0], 1'b0};
                    miso_d     = tx_shift_q[SIZE-2];
                end
            end
            default: state_d = ST_WAIT_HIGH;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q    <= ST_WAIT_HIGH;
            settle_q   <= '0;
            bit_cnt_q  <= '0;
            data_out_q <= '0;
            miso_q     <= 1'b0;
            oe_q       <= 1'b0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            settle_q   <= settle_d;
            bit_cnt_q  <= bit_cnt_d;
            data_out_q <= data_out_d;
            miso_q     <= miso_d;
            oe_q       <= oe_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk_in) begin
        tx_shift_q <= tx_shift_d;
        rx_shift_q <= rx_shift_d;
    end

    assign miso_out        = miso_q;
    assign miso_oe_out     = oe_q;
    assign data_out        = data_out_q;
    assign r_valid_out     = valid_q;
    assign r_frame_err_out = err_q;
    assign r_busy_out      = busy_q;

endmodule

// File: tb/tb_spi_target.sv
// Bench for spi_target: drives the SPI pins as a mode-0 master and checks
// against a bit-queue model of what the target should receive and return.
module tb_spi_target;

    localparam int SIZE = 40;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            sck = 1'b0;
    logic            cs_n = 1'b1;
    logic            mosi = 1'b0;
    logic            miso, miso_oe, valid, ferr, busy;
    logic [SIZE-1:0] din = '0;
    logic [SIZE-1:0] dout;

    int              total = 0;
    int              bad = 0;
    logic [SIZE-1:0] exp_dout = '0;

    always #5 clk = ~clk;

    spi_target #(.SIZE(SIZE), .CNT_WIDTH(6)) dut (
        .clk_in          (clk),
        .reset_n_in      (rst_n),
        .sck_in          (sck),
        .cs_n_in         (cs_n),
        .mosi_in         (mosi),
        .miso_out        (miso),
        .miso_oe_out     (miso_oe),
        .data_in         (din),
        .data_out        (dout),
        .r_valid_out     (valid),
        .r_frame_err_out (ferr),
        .r_busy_out      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ":miso"},  64'(miso),    64'(0));
        chk({tag, ":oe"},    64'(miso_oe), 64'(0));
        chk({tag, ":dout"},  64'(dout),    64'(0));
        chk({tag, ":valid"}, 64'(valid),   64'(0));
        chk({tag, ":err"},   64'(ferr),    64'(0));
        chk({tag, ":busy"},  64'(busy),    64'(0));
    endtask

    // One master transaction of nbits SCK cycles, CS held high for gap cycles afterwards
    task automatic run_frame(input logic [SIZE-1:0] tx_word, input int nbits,
                             input logic [SIZE-1:0] resp, input int gap, input string tag);
        bit              sent[$];
        logic [SIZE-1:0] rx_master = '0;
        logic [SIZE-1:0] rx_word = '0;
        int              n_cap;
        int              vcnt = 0, ecnt = 0, vpos = 0, epos = 0;
        logic            b;
        din  = resp;
        cs_n = 1'b0;
        wait_neg(4);
        chk({tag, ":busy_hi"}, 64'(busy),    64'(1));
        chk({tag, ":oe_hi"},   64'(miso_oe), 64'(1));
        for (int i = 0; i < nbits; i++) begin
            b = (i < SIZE) ? tx_word[SIZE-1-i] : 1'($urandom);
            mosi = b;
            sent.push_back(b);
            wait_neg(4);
            if (i < SIZE) rx_master = {rx_master[SIZE-2:0], miso};
            else chk({tag, ":miso_past_end"}, 64'(miso), 64'(0));
            sck = 1'b1;
            wait_neg(4);
            sck = 1'b0;
        end
        wait_neg(4);
        cs_n = 1'b1;
        for (int k = 1; k <= gap; k++) begin
            @(negedge clk);
            if (valid) begin vcnt++; vpos = k; end
            if (ferr)  begin ecnt++; epos = k; end
        end
        n_cap = (nbits < SIZE) ? nbits : SIZE;
        chk({tag, ":miso_word"}, 64'(rx_master), 64'(resp >> (SIZE - n_cap)));
        if (nbits == SIZE) begin
            for (int i = 0; i < SIZE; i++) rx_word = {rx_word[SIZE-2:0], sent[sent.size()-SIZE+i]};
            exp_dout = rx_word;
            chk({tag, ":valid_cnt"}, 64'(vcnt), 64'(1));
            chk({tag, ":valid_lat"}, 64'(vpos), 64'(3));
            chk({tag, ":err_cnt"},   64'(ecnt), 64'(0));
        end else begin
            chk({tag, ":valid_cnt"}, 64'(vcnt), 64'(0));
            chk({tag, ":err_cnt"},   64'(ecnt), 64'(1));
            chk({tag, ":err_lat"},   64'(epos), 64'(3));
        end
        chk({tag, ":dout"},    64'(dout),    64'(exp_dout));
        chk({tag, ":busy_lo"}, 64'(busy),    64'(0));
        chk({tag, ":oe_lo"},   64'(miso_oe), 64'(0));
    endtask

    initial begin
        int vcnt, ecnt, act;
        logic [SIZE-1:0] w, r;
        int n, g;

        wait_neg(3);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        wait_neg(6);

        run_frame(40'h81_DEAD_BEEF, SIZE, 40'hA5_1234_5678, 8, "full");
        chk("full:dout_const", 64'(dout), 64'(40'h81_DEAD_BEEF));
        run_frame(40'h12_3456_789A, 39, 40'h0F_F0F0_0F0F, 8, "short");
        run_frame(40'hFE_DCBA_9876, 41, 40'h55_AAAA_5555, 8, "long");

        // Reset in the middle of a frame, CS kept low across the reset
        din  = 40'hC3_C3C3_C3C3;
        cs_n = 1'b0;
        wait_neg(4);
        for (int i = 0; i < 20; i++) begin
            mosi = 1'($urandom);
            wait_neg(4);
            sck = 1'b1;
            wait_neg(4);
            sck = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        exp_dout = '0;
        wait_neg(3);
        rst_n = 1'b1;
        wait_neg(6);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1; wait_neg(4); sck = 1'b0; wait_neg(4);
        end
        cs_n = 1'b1;
        vcnt = 0; ecnt = 0; act = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (valid) vcnt++;
            if (ferr)  ecnt++;
            if (busy || miso_oe) act++;
        end
        chk("midrst:valid_cnt", 64'(vcnt), 64'(0));
        chk("midrst:err_cnt",   64'(ecnt), 64'(0));
        chk("midrst:active",    64'(act),  64'(0));
        chk("midrst:dout",      64'(dout), 64'(0));
        run_frame(40'h00_0000_0001, SIZE, 40'h9C_8B7A_6958, 8, "post_rst");

        // SCK toggling with CS high must be ignored
        vcnt = 0; ecnt = 0; act = 0;
        for (int k = 0; k < 80; k++) begin
            if (k % 4 == 0) sck = ~sck;
            @(negedge clk);
            if (valid) vcnt++;
            if (ferr)  ecnt++;
            if (busy || miso_oe) act++;
        end
        sck = 1'b0;
        wait_neg(4);
        chk("idle_sck:valid_cnt", 64'(vcnt), 64'(0));
        chk("idle_sck:err_cnt",   64'(ecnt), 64'(0));
        chk("idle_sck:active",    64'(act),  64'(0));
        chk("idle_sck:dout",      64'(dout), 64'(exp_dout));

        run_frame(40'h3C_5A69_96A5, SIZE, 40'hA5_1234_5678, 3, "b2b_1");
        run_frame(40'h77_0102_0304, SIZE, 40'h11_2233_4455, 8, "b2b_2");

        for (int t = 0; t < 25; t++) begin
            w = SIZE'({$urandom, $urandom});
            r = SIZE'({$urandom, $urandom});
            case ($urandom_range(0, 3))
                0, 3: n = SIZE;
                1:    n = $urandom_range(0, 45);
                default: n = ($urandom_range(0, 1) == 0) ? SIZE - 1 : SIZE + 1;
            endcase
            g = $urandom_range(3, 10);
            run_frame(w, n, r, g, $sformatf("rnd%0d", t));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
